// File: rtl/sme_dom_alu_if.sv
// Handshake and share-bus bundle for sme_dom_alu: operand/randomness inputs and result outputs.
interface sme_dom_alu_if #(
    parameter int D = 2,
    parameter int N = 32
);
    localparam int RW = N * D * (D - 1) / 2;

    logic              in_valid;
    logic              in_ready;
    logic [1:0]        op;
    logic [N*D-1:0]    rs1;
    logic [N*D-1:0]    rs2;
    logic [RW-1:0]     rng;
    logic              rng_valid;
    logic              rng_ready;
    logic              out_valid;
    logic              out_ready;
    logic [N*D-1:0]    rd;
    logic [31:0]       rng_count;

    modport master (
        output in_valid, op, rs1, rs2, rng, rng_valid, out_ready,
        input  in_ready, rng_ready, out_valid, rd, rng_count
    );

    modport slave (
        input  in_valid, op, rs1, rs2, rng, rng_valid, out_ready,
        output in_ready, rng_ready, out_valid, rd, rng_count
    );
endinterface

// File: rtl/sme_dom_alu.sv
// Two-stage DOM-masked AND/OR/XOR/ANDN unit on D-share operands with valid/ready flow control.
// Define SME_DOM_XOR_REFRESH_EN to also refresh XOR results with fresh randomness.
module sme_dom_alu #(
    parameter int D = 2,
    parameter int N = 32
) (
    input  logic         g_clk,
    input  logic         g_reset,
    input  logic         flush,
    sme_dom_alu_if.slave bus
);
    localparam int P = D * (D - 1) / 2;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_ANDN = 2'b11;

    logic             r_s1_valid;
    logic             r_out_valid;
    logic [1:0]       r_op;
    logic [N*D-1:0]   r_rd;
    logic [31:0]      r_rng_count;

    logic [D*D*N-1:0] w_terms_q;
    logic [N*D-1:0]   w_rd_next;
    logic [N-1:0]     w_a [D];
    logic [N-1:0]     w_b [D];
    logic [N-1:0]     w_refresh [D];
    logic             w_needs_rng;
    logic             w_s2_free;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_rng_ready;
    logic             w_s1_adv;
    logic             w_xor_path;
    logic             w_inv_a;
    logic             w_inv_b;

    // OR is De Morgan over AND, ANDN inverts only rs2; linear NOT touches share 0 only.
    assign w_xor_path = (bus.op == OP_XOR);
    assign w_inv_a    = (bus.op == OP_OR);
    assign w_inv_b    = (bus.op == OP_OR) || (bus.op == OP_ANDN);

`ifdef SME_DOM_XOR_REFRESH_EN
    assign w_needs_rng = 1'b1;
    always_comb begin
        w_refresh[D-1] = '0;
        for (int s = 0; s < D - 1; s++) begin
            w_refresh[s]   = bus.rng[s*N +: N];
            w_refresh[D-1] = w_refresh[D-1] ^ bus.rng[s*N +: N];
        end
    end
`else
    assign w_needs_rng = !w_xor_path;
    always_comb begin
        for (int s = 0; s < D; s++) begin
            w_refresh[s] = '0;
        end
    end
`endif

    assign w_s2_free   = !r_out_valid || bus.out_ready;
    assign w_in_ready  = !flush && (!r_s1_valid || w_s2_free);
    assign w_accept    = !g_reset && bus.in_valid && w_in_ready && (bus.rng_valid || !w_needs_rng);
    assign w_rng_ready = w_accept && w_needs_rng;
    assign w_s1_adv    = r_s1_valid && w_s2_free;

    genvar gi, gj, gb;
    generate
        for (gi = 0; gi < D; gi++) begin : g_share
            assign w_a[gi] = bus.rs1[gi*N +: N] ^ {N{(gi == 0) && w_inv_a}};
            assign w_b[gi] = bus.rs2[gi*N +: N] ^ {N{(gi == 0) && w_inv_b}};

            for (gj = 0; gj < D; gj++) begin : g_term
                logic [N-1:0] w_term;
                logic [N-1:0] r_term;

                if (gi == gj) begin : g_diag
                    assign w_term = w_xor_path ? (w_a[gi] ^ w_b[gi] ^ w_refresh[gi])
                                               : (w_a[gi] & w_b[gi]);
                end else begin : g_cross
                    // Both (i,j) and (j,i) share the pair bit so the cross masks cancel.
                    localparam int LO = (gi < gj) ? gi : gj;
                    localparam int HI = (gi < gj) ? gj : gi;
                    logic [N-1:0] w_pair;
                    for (gb = 0; gb < N; gb++) begin : g_bit
                        assign w_pair[gb] = bus.rng[gb*P + LO + HI*(HI-1)/2];
                    end
                    assign w_term = w_xor_path ? '0 : ((w_a[gi] & w_b[gj]) ^ w_pair);
                end

                always_ff @(posedge g_clk or posedge g_reset) begin
                    if (g_reset) begin
                        r_term <= '0;
                    end else if (w_accept) begin
                        r_term <= w_term;
                    end
                end

                assign w_terms_q[(gi*D+gj)*N +: N] = r_term;
            end
        end
    endgenerate

    always_comb begin
        w_rd_next = '0;
        for (int i = 0; i < D; i++) begin
            for (int j = 0; j < D; j++) begin
                w_rd_next[i*N +: N] = w_rd_next[i*N +: N] ^ w_terms_q[(i*D+j)*N +: N];
            end
        end
        if (r_op == OP_OR) begin
            w_rd_next[N-1:0] = ~w_rd_next[N-1:0];
        end
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_op        <= '0;
            r_rd        <= '0;
            r_rng_count <= '0;
        end else begin
            if (flush) begin
                r_s1_valid <= 1'b0;
            end else if (w_accept) begin
                r_s1_valid <= 1'b1;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end

            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_s1_adv) begin
                r_out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_accept) begin
                r_op <= bus.op;
            end
            if (w_s1_adv) begin
                r_rd <= w_rd_next;
            end
            if (w_rng_ready) begin
                r_rng_count <= r_rng_count + 32'd1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.rng_ready = w_rng_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.rd        = r_rd;
    assign bus.rng_count = r_rng_count;
endmodule
